// File: rtl/dec_pingpong_ram.sv
// dec_pingpong_ram: multi-bank hard-decision frame store between the
// LDPC decoder (writer) and the output unloader (reader).
module dec_pingpong_ram #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int NUM_BANKS  = 2,
  localparam int BANK_W    = $clog2(NUM_BANKS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_done,
  output logic                  wr_ready,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_done,
  output logic                  rd_avail,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [BANK_W-1:0]     wr_bank,
  output logic [BANK_W-1:0]     rd_bank,
  output logic [BANK_W:0]       full_cnt,
  output logic                  err_ovf,
  output logic                  err_udf
);

  localparam logic [BANK_W:0]   FULL = (BANK_W+1)'(NUM_BANKS);
  localparam logic [BANK_W-1:0] LAST = BANK_W'(NUM_BANKS - 1);

  logic [DATA_WIDTH-1:0] mem [NUM_BANKS][RAM_DEPTH];

  logic wr_ok;
  logic rd_ok;
  logic wdone_ok;
  logic rdone_ok;
  logic ovf_hit;
  logic udf_hit;

  function automatic logic [BANK_W-1:0] bump(
    input logic [BANK_W-1:0] b
  );
    return (b == LAST) ? '0 : b + 1'b1;
  endfunction

  assign wr_ready = (full_cnt < FULL);
  assign rd_avail = (full_cnt != '0);

  assign wr_ok    = wr_en & wr_ready;
  assign rd_ok    = rd_en & rd_avail;
  assign wdone_ok = wr_done & wr_ready;
  assign rdone_ok = rd_done & rd_avail;
  assign ovf_hit  = (wr_en | wr_done) & ~wr_ready;
  assign udf_hit  = (rd_en | rd_done) & ~rd_avail;

  // Storage is never reset; only the control state is.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_bank][wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (rd_ok) begin
        rd_data <= mem[rd_bank][rd_addr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= '0;
      rd_bank <= '0;
    end else begin
      if (wdone_ok) begin
        wr_bank <= bump(wr_bank);
      end
      if (rdone_ok) begin
        rd_bank <= bump(rd_bank);
      end
    end
  end

  // Simultaneous accepted done pulses cancel in the occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_cnt <= '0;
    end else begin
      unique case ({wdone_ok, rdone_ok})
        2'b10:   full_cnt <= full_cnt + 1'b1;
        2'b01:   full_cnt <= full_cnt - 1'b1;
        default: full_cnt <= full_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      err_ovf <= err_ovf | ovf_hit;
      err_udf <= err_udf | udf_hit;
    end
  end

endmodule

// File: tb/tb_dec_pingpong_ram.sv
// tb_dec_pingpong_ram: randomized and directed checks of the bank store
// against a frame-counting reference model (2-bank and 3-bank instances).
module tb_dec_pingpong_ram;

  localparam int DW    = 1;
  localparam int AW    = 8;
  localparam int DEPTH = 256;
  localparam int F3    = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          wr_en = 0, wr_done = 0, rd_en = 0, rd_done = 0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready, rd_avail, rd_valid, err_ovf, err_udf;
  logic [DW-1:0] rd_data;
  logic [0:0]    wr_bank, rd_bank;
  logic [1:0]    full_cnt;

  logic          t_wr_en = 0, t_wr_done = 0, t_rd_en = 0, t_rd_done = 0;
  logic [AW-1:0] t_wr_addr = '0, t_rd_addr = '0;
  logic [DW-1:0] t_wr_data = '0;
  logic          t_wr_ready, t_rd_avail, t_rd_valid, t_err_ovf, t_err_udf;
  logic [DW-1:0] t_rd_data;
  logic [1:0]    t_wr_bank, t_rd_bank;
  logic [2:0]    t_full_cnt;

  dec_pingpong_ram #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_done(wr_done), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_done(rd_done),
    .rd_avail(rd_avail), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_bank(wr_bank), .rd_bank(rd_bank), .full_cnt(full_cnt),
    .err_ovf(err_ovf), .err_udf(err_udf)
  );

  dec_pingpong_ram #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(3)
  ) dut3 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(t_wr_en), .wr_addr(t_wr_addr), .wr_data(t_wr_data),
    .wr_done(t_wr_done), .wr_ready(t_wr_ready),
    .rd_en(t_rd_en), .rd_addr(t_rd_addr), .rd_done(t_rd_done),
    .rd_avail(t_rd_avail), .rd_data(t_rd_data), .rd_valid(t_rd_valid),
    .wr_bank(t_wr_bank), .rd_bank(t_rd_bank), .full_cnt(t_full_cnt),
    .err_ovf(t_err_ovf), .err_udf(t_err_udf)
  );

  int total = 0;
  int bad = 0;

  // Reference model: frames written/read as counters, memory as arrays.
  logic [DW-1:0] m_mem [2][DEPTH];
  bit            m_known [2][DEPTH];
  int            wf, rf;
  bit            m_ovf, m_udf, m_valid, m_dknown;
  logic [DW-1:0] m_data;

  task automatic model_reset();
    wf = 0; rf = 0;
    m_ovf = 0; m_udf = 0; m_valid = 0;
    m_data = '0; m_dknown = 1;
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_done = 0; rd_en = 0; rd_done = 0;
    t_wr_en = 0; t_wr_done = 0; t_rd_en = 0; t_rd_done = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic step(input bit we, input int wa, input logic [DW-1:0] wd,
                      input bit wdn, input bit re, input int ra,
                      input bit rdn);
    int full, wb, rb;
    bit wrdy, ravl;
    wr_en = we; wr_addr = wa[AW-1:0]; wr_data = wd; wr_done = wdn;
    rd_en = re; rd_addr = ra[AW-1:0]; rd_done = rdn;
    full = wf - rf; wb = wf % 2; rb = rf % 2;
    wrdy = full < 2; ravl = full != 0;
    @(posedge clk);
    if (re && ravl) begin
      m_valid = 1; m_data = m_mem[rb][ra]; m_dknown = m_known[rb][ra];
    end else begin
      m_valid = 0;
      if (re) m_udf = 1;
    end
    if (we) begin
      if (wrdy) begin
        m_mem[wb][wa] = wd; m_known[wb][wa] = 1;
      end else m_ovf = 1;
    end
    if (wdn) begin
      if (wrdy) wf++;
      else m_ovf = 1;
    end
    if (rdn) begin
      if (ravl) rf++;
      else m_udf = 1;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset();
    apply_reset();
    step(0, 0, '0, 0, 0, 0, 0);
    step(0, 0, '0, 0, 0, 0, 0);
    total++; if (wr_ready !== 1'b1) begin bad++;
      $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
    total++; if (rd_avail !== 1'b0) begin bad++;
      $display("FAIL reset_rd_avail got=%b exp=0", rd_avail); end
    total++; if (full_cnt !== 2'd0) begin bad++;
      $display("FAIL reset_full_cnt got=%0d exp=0", full_cnt); end
    total++; if (rd_valid !== 1'b0 || rd_data !== '0) begin bad++;
      $display("FAIL reset_rd got v=%b d=%h exp v=0 d=0", rd_valid, rd_data); end
    total++; if (err_ovf !== 1'b0 || err_udf !== 1'b0) begin bad++;
      $display("FAIL reset_err got ovf=%b udf=%b exp 0 0", err_ovf, err_udf); end
    total++; if (wr_bank !== 1'b0 || rd_bank !== 1'b0) begin bad++;
      $display("FAIL reset_banks got wb=%0d rb=%0d exp 0 0", wr_bank, rd_bank); end
  endtask

  task automatic test_frame();
    for (int a = 0; a < DEPTH; a++) step(1, a, DW'(a % 2), 0, 0, 0, 0);
    step(0, 0, '0, 1, 0, 0, 0);
    total++; if (full_cnt !== 2'd1 || wr_bank !== 1'b1 || rd_avail !== 1'b1)
      begin bad++; $display("FAIL frame_done got full=%0d wb=%0d avail=%b exp 1 1 1",
        full_cnt, wr_bank, rd_avail); end
    for (int a = 0; a < DEPTH; a++) begin
      step(0, 0, '0, 0, 1, a, 0);
      total++;
      if (rd_valid !== 1'b1 || rd_data !== DW'(a % 2)) begin bad++;
        $display("FAIL frame_read a=%0d got v=%b d=%h exp v=1 d=%0d",
          a, rd_valid, rd_data, a % 2); end
    end
    step(0, 0, '0, 0, 0, 0, 0);
    total++; if (rd_valid !== 1'b0 || rd_data !== DW'(1)) begin bad++;
      $display("FAIL frame_hold got v=%b d=%h exp v=0 d=1", rd_valid, rd_data); end
    step(0, 0, '0, 0, 0, 0, 1);
    total++; if (full_cnt !== 2'd0 || rd_bank !== 1'b1) begin bad++;
      $display("FAIL frame_rd_done got full=%0d rb=%0d exp 0 1", full_cnt, rd_bank); end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] orig;
    apply_reset();
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < DEPTH; a++)
        step(1, a, (a == 5) ? DW'(0) : DW'($urandom), 0, 0, 0, 0);
      step(0, 0, '0, 1, 0, 0, 0);
    end
    orig = m_mem[0][5];
    total++; if (full_cnt !== 2'd2 || wr_ready !== 1'b0 || err_ovf !== 1'b0)
      begin bad++; $display("FAIL ovf_full got full=%0d rdy=%b ovf=%b exp 2 0 0",
        full_cnt, wr_ready, err_ovf); end
    step(1, 5, DW'(1), 0, 0, 0, 0);
    total++; if (err_ovf !== 1'b1 || full_cnt !== 2'd2) begin bad++;
      $display("FAIL ovf_flag got ovf=%b full=%0d exp 1 2", err_ovf, full_cnt); end
    step(0, 0, '0, 0, 1, 5, 0);
    total++; if (rd_valid !== 1'b1 || rd_data !== orig || rd_bank !== 1'b0)
      begin bad++; $display("FAIL ovf_protect got v=%b d=%h rb=%0d exp v=1 d=%h rb=0",
        rd_valid, rd_data, rd_bank, orig); end
  endtask

  task automatic test_simul();
    apply_reset();
    for (int a = 0; a < 8; a++) step(1, a, DW'($urandom), 0, 0, 0, 0);
    step(0, 0, '0, 1, 0, 0, 0);
    step(0, 0, '0, 1, 0, 0, 1);
    total++; if (full_cnt !== 2'd1) begin bad++;
      $display("FAIL simul_full got=%0d exp=1", full_cnt); end
    total++; if (wr_bank !== 1'b0 || rd_bank !== 1'b1) begin bad++;
      $display("FAIL simul_banks got wb=%0d rb=%0d exp 0 1", wr_bank, rd_bank); end
  endtask

  task automatic test_underflow();
    apply_reset();
    step(0, 0, '0, 0, 1, 3, 0);
    total++; if (rd_valid !== 1'b0 || err_udf !== 1'b1 || rd_data !== '0)
      begin bad++; $display("FAIL udf_read got v=%b udf=%b d=%h exp 0 1 0",
        rd_valid, err_udf, rd_data); end
    step(0, 0, '0, 0, 0, 0, 1);
    total++; if (full_cnt !== 2'd0 || rd_bank !== 1'b0 || err_ovf !== 1'b0)
      begin bad++; $display("FAIL udf_done got full=%0d rb=%0d ovf=%b exp 0 0 0",
        full_cnt, rd_bank, err_ovf); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      step($urandom % 2, $urandom % DEPTH, DW'($urandom),
           ($urandom % 10) == 0, $urandom % 2, $urandom % DEPTH,
           ($urandom % 10) == 0);
      total++;
      if (rd_valid !== m_valid || (m_valid && m_dknown && rd_data !== m_data))
        begin bad++; $display("FAIL rand_read c=%0d got v=%b d=%h exp v=%b d=%h",
          c, rd_valid, rd_data, m_valid, m_data); end
      total++;
      if (full_cnt !== 2'(wf - rf) || wr_bank !== 1'(wf % 2) ||
          rd_bank !== 1'(rf % 2)) begin bad++;
        $display("FAIL rand_state c=%0d got full=%0d wb=%0d rb=%0d exp %0d %0d %0d",
          c, full_cnt, wr_bank, rd_bank, wf - rf, wf % 2, rf % 2); end
      total++;
      if (wr_ready !== (wf - rf < 2) || rd_avail !== (wf != rf) ||
          err_ovf !== m_ovf || err_udf !== m_udf) begin bad++;
        $display("FAIL rand_flags c=%0d got rdy=%b av=%b ovf=%b udf=%b exp %b %b %b %b",
          c, wr_ready, rd_avail, err_ovf, err_udf,
          (wf - rf < 2), (wf != rf), m_ovf, m_udf); end
    end
  endtask

  task automatic test_three_banks();
    logic [DW-1:0] exp3 [5][F3];
    bit op_wr [10] = '{1, 1, 1, 0, 1, 0, 1, 0, 0, 0};
    int op_fr [10] = '{0, 1, 2, 0, 3, 1, 4, 2, 3, 4};
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      int f;
      f = op_fr[i];
      if (op_wr[i]) begin
        total++; if (t_wr_bank !== 2'(f % 3) || t_wr_ready !== 1'b1) begin bad++;
          $display("FAIL nb3_wr_bank f=%0d got wb=%0d rdy=%b exp %0d 1",
            f, t_wr_bank, t_wr_ready, f % 3); end
        for (int a = 0; a < F3; a++) begin
          exp3[f][a] = DW'($urandom);
          t_wr_en = 1; t_wr_addr = AW'(a); t_wr_data = exp3[f][a];
          t_wr_done = (a == F3 - 1);
          @(negedge clk);
        end
        t_wr_en = 0; t_wr_done = 0;
      end else begin
        total++; if (t_rd_bank !== 2'(f % 3) || t_rd_avail !== 1'b1) begin bad++;
          $display("FAIL nb3_rd_bank f=%0d got rb=%0d av=%b exp %0d 1",
            f, t_rd_bank, t_rd_avail, f % 3); end
        for (int a = 0; a < F3; a++) begin
          t_rd_en = 1; t_rd_addr = AW'(a); t_rd_done = (a == F3 - 1);
          @(negedge clk);
          t_rd_en = 0; t_rd_done = 0;
          total++;
          if (t_rd_valid !== 1'b1 || t_rd_data !== exp3[f][a]) begin bad++;
            $display("FAIL nb3_data f=%0d a=%0d got v=%b d=%h exp v=1 d=%h",
              f, a, t_rd_valid, t_rd_data, exp3[f][a]); end
        end
      end
      if (i == 2) begin
        total++; if (t_full_cnt !== 3'd3 || t_wr_ready !== 1'b0) begin bad++;
          $display("FAIL nb3_full got full=%0d rdy=%b exp 3 0",
            t_full_cnt, t_wr_ready); end
      end
    end
    total++; if (t_full_cnt !== 3'd0 || t_err_ovf !== 1'b0 || t_err_udf !== 1'b0)
      begin bad++; $display("FAIL nb3_end got full=%0d ovf=%b udf=%b exp 0 0 0",
        t_full_cnt, t_err_ovf, t_err_udf); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    step(0, 0, '0, 0, 1, 0, 0);
    step(1, 0, DW'(1), 0, 0, 0, 0);
    step(1, 1, DW'(0), 1, 0, 0, 0);
    step(0, 0, '0, 0, 1, 0, 0);
    total++; if (full_cnt !== 2'd1 || wr_bank !== 1'b1 || rd_valid !== 1'b1 ||
        rd_data !== DW'(1) || err_udf !== 1'b1) begin bad++;
      $display("FAIL arst_pre got full=%0d wb=%0d v=%b d=%h udf=%b exp 1 1 1 1 1",
        full_cnt, wr_bank, rd_valid, rd_data, err_udf); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (full_cnt !== 2'd0 || wr_bank !== 1'b0 || rd_bank !== 1'b0)
      begin bad++; $display("FAIL arst_state got full=%0d wb=%0d rb=%0d exp 0 0 0",
        full_cnt, wr_bank, rd_bank); end
    total++; if (rd_valid !== 1'b0 || rd_data !== '0 || err_udf !== 1'b0 ||
        err_ovf !== 1'b0 || wr_ready !== 1'b1 || rd_avail !== 1'b0) begin bad++;
      $display("FAIL arst_out got v=%b d=%h udf=%b ovf=%b rdy=%b av=%b exp 0 0 0 0 1 0",
        rd_valid, rd_data, err_udf, err_ovf, wr_ready, rd_avail); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_frame();
    test_overflow();
    test_simul();
    test_underflow();
    test_random();
    test_three_banks();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
